// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin scheduler sharing one iterative WxW shift-add
// multiplier among NREQ valid/ready requesters. Each accepted operand pair is
// multiplied over W cycles and returned as a 2W-bit product tagged with the
// requester id.
// Optional build macro: ZERO_SKIP_EN -- when defined, a transaction whose q or
// m is zero at accept bypasses RUN and goes straight to DONE with product 0.
module mul_share_sched #(
   parameter int NREQ = 4,
   parameter int W    = 4,
   parameter int IDW  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [W*NREQ-1:0]   req_q,
   input  logic [W*NREQ-1:0]   req_m,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [2*W-1:0]      rsp_product,
   output logic [IDW-1:0]      rsp_id,
   output logic                busy
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   ptr, ptr_nxt;
   logic [IDW-1:0]   grant, idx;
   logic             grant_vld;
   logic [W-1:0]     q_sel, m_sel;
   logic [W-1:0]     q_r, m_r;
   logic [IDW-1:0]   id_r;
   logic [2*W-1:0]   acc, acc_nxt;
   logic [CW-1:0]    cnt;
   logic             last_step;
   logic             zero_op;

   // Round-robin search: first valid requester starting at ptr, wrapping at NREQ.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      grant     = '0;
      grant_vld = 1'b0;
      idx       = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (!grant_vld && req_valid[idx]) begin
            grant_vld = 1'b1;
            grant     = idx;
         end
      end
   end

   // Operand mux, next pointer, shift-add step and zero-operand detect.
   always_comb begin
      q_sel     = req_q[W*grant +: W];
      m_sel     = req_m[W*grant +: W];
      ptr_nxt   = IDW'((int'(grant) + 1) % NREQ);
      last_step = (cnt == CW'(W - 1));
      acc_nxt   = m_r[cnt] ? acc + ({{W{1'b0}}, q_r} << cnt) : acc;
`ifdef ZERO_SKIP_EN
      zero_op   = (q_sel == '0) || (m_sel == '0);
`else
      zero_op   = 1'b0;
`endif
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next-state and grant decode; accepts only in IDLE and never during reset.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      unique case (state)
         IDLE: begin
            if (grant_vld) begin
               req_ready[grant] = ~rst;
               state_nxt        = zero_op ? DONE : RUN;
            end
         end
         RUN:  if (last_step) state_nxt = DONE;
         DONE: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign rsp_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // Datapath: latch operands on accept, accumulate during RUN, publish the result into DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr         <= '0;
         q_r         <= '0;
         m_r         <= '0;
         id_r        <= '0;
         acc         <= '0;
         cnt         <= '0;
         rsp_product <= '0;
         rsp_id      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant_vld) begin
                  q_r  <= q_sel;
                  m_r  <= m_sel;
                  id_r <= grant;
                  acc  <= '0;
                  cnt  <= '0;
                  ptr  <= ptr_nxt;
                  if (zero_op) begin
                     rsp_product <= '0;
                     rsp_id      <= grant;
                  end
               end
            end
            RUN: begin
               acc <= acc_nxt;
               cnt <= cnt + CW'(1);
               if (last_step) begin
                  rsp_product <= acc_nxt;
                  rsp_id      <= id_r;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched (NREQ=4, W=4) with hand-computed products,
// latencies, grant order, back-pressure and mid-operation reset.
module tb_mul_share_sched;

   localparam int NREQ = 4;
   localparam int W    = 4;
   localparam int IDW  = 2;
   localparam int LAT  = W + 1;
`ifdef ZERO_SKIP_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = W + 1;
`endif

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [W*NREQ-1:0] req_q;
   logic [W*NREQ-1:0] req_m;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [2*W-1:0]    rsp_product;
   logic [IDW-1:0]    rsp_id;
   logic              busy;

   int n_vec = 0;
   int n_err = 0;

   mul_share_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_q       (req_q),
      .req_m       (req_m),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_product (rsp_product),
      .rsp_id      (rsp_id),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the run can never hang.
   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_op(input int i, input int q, input int m);
      req_q[W*i +: W] = W'(q);
      req_m[W*i +: W] = W'(m);
   endtask

   // Called in an IDLE cycle with inputs already settled: checks the grant,
   // steps through the multiply, checks latency/result and, if rsp_ready is
   // high, the return to IDLE after the handshake.
   task automatic run_txn(input string tag, input int exp_id, input int exp_prod,
                          input int exp_lat, input bit drop);
      int cyc;
      bit quiet_ok;
      check({tag, " ready"}, 32'(req_ready), 32'(1) << exp_id);
      @(posedge clk); #1;
      if (drop) req_valid[exp_id] = 1'b0;
      cyc      = 1;
      quiet_ok = 1'b1;
      while (!rsp_valid && cyc < 20) begin
         if (!busy || req_ready != '0) quiet_ok = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      if (!busy || req_ready != '0) quiet_ok = 1'b0;
      check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
      check({tag, " busy/quiet"}, 32'(quiet_ok), 32'd1);
      check({tag, " product"}, 32'(rsp_product), 32'(exp_prod));
      check({tag, " id"}, 32'(rsp_id), 32'(exp_id));
      if (rsp_ready) begin
         @(posedge clk); #1;
         check({tag, " idle"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      bit ok;
      rst       = 1'b1;
      req_valid = 4'b1111;
      req_q     = '0;
      req_m     = '0;
      rsp_ready = 1'b1;
      #1;
      check("reset req_ready", 32'(req_ready), 32'd0);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset product", 32'(rsp_product), 32'd0);
      check("reset id", 32'(rsp_id), 32'd0);
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: single requester 0, 4*3
      set_op(0, 4, 3);
      req_valid = 4'b0001;
      #1;
      run_txn("t1", 0, 12, LAT, 1'b1);

      // 2: requester 1, max operands 15*15
      set_op(1, 15, 15);
      req_valid = 4'b0010;
      #1;
      run_txn("t2", 1, 225, LAT, 1'b1);

      // 5: reset in RUN cycle 2 aborts the transaction and clears ptr (was 3 after accept)
      set_op(2, 9, 9);
      req_valid = 4'b0100;
      #1;
      check("t5 ready", 32'(req_ready), 32'b0100);
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); #1;
      req_valid = 4'b0100;
      rst = 1'b1;
      #1;
      check("t5 rsp_valid in rst", 32'(rsp_valid), 32'd0);
      check("t5 busy in rst", 32'(busy), 32'd0);
      check("t5 ready in rst", 32'(req_ready), 32'd0);
      req_valid = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      ok = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      end
      check("t5 no response", 32'(ok), 32'd1);

      // 3: all valid from ptr=0 -> grants 0,1,2,3 in order
      set_op(0, 7, 5);
      set_op(1, 2, 3);
      set_op(2, 15, 1);
      set_op(3, 0, 8);
      req_valid = 4'b1111;
      #1;
      run_txn("t3 g0", 0, 35, LAT, 1'b0);
      run_txn("t3 g1", 1, 6, LAT, 1'b0);
      run_txn("t3 g2", 2, 15, LAT, 1'b0);
      run_txn("t3 g3", 3, 0, ZLAT, 1'b0);
      // ptr wrapped to 0: id 0 before id 3
      req_valid = 4'b1001;
      #1;
      run_txn("t3 w0", 0, 35, LAT, 1'b0);
      run_txn("t3 w3", 3, 0, ZLAT, 1'b1);
      req_valid = '0;

      // 4: back-pressure in DONE for 10 cycles
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      #1;
      run_txn("t4", 0, 35, LAT, 1'b1);
      req_valid = 4'b0010;
      set_op(1, 3, 5);
      ok = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_product !== 8'd35 || rsp_id !== 2'd0 ||
             req_ready !== 4'b0000 || busy !== 1'b1) ok = 1'b0;
      end
      check("t4 stall stable", 32'(ok), 32'd1);
      rsp_ready = 1'b1;
      #1;
      check("t4 busy before edge", 32'(busy), 32'd1);
      check("t4 no accept in handshake", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check("t4 idle after handshake", 32'(busy), 32'd0);
      run_txn("t4 next", 1, 15, LAT, 1'b1);
      req_valid = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
